// File: rtl/fir_coeff_loader_if.sv
// Coefficient word stream into the FIR coefficient loader.
// valid/ready handshake, with s_last marking the final word of a frame.
interface fir_coeff_loader_if #(
  parameter int COEF_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [COEF_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered, runtime-loadable coefficient bank for the 63-tap FIR.
// A frame fills the shadow bank; after a commit, the banks swap on the next sample_tick.
module fir_coeff_loader #(
  parameter int TAPS   = 63,
  parameter int COEF_W = 32,
  parameter int IDX_W  = $clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_coeff_loader_if.slave      coef_in,
  input  logic                   commit,
  input  logic                   sample_tick,
  output logic [TAPS*COEF_W-1:0] coef_flat,
  output logic                   bank_sel,
  output logic                   armed,
  output logic                   swap_done,
  output logic                   err_len
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_PENDING = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s, wr_idx_s;
  logic              wr_s, swap_s, err_nxt_s, xfer_s;
  logic              s_ready_r, armed_r, bank_sel_r, swap_done_r, err_len_r;
  logic [COEF_W-1:0] active_r [TAPS];
  logic [COEF_W-1:0] shadow_r [TAPS];

  assign xfer_s = coef_in.s_valid & s_ready_r;

  // Frame sequencing: write index, length checking and the commit/swap hand-off.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    wr_idx_s    = idx_r;
    wr_s        = 1'b0;
    swap_s      = 1'b0;
    err_nxt_s   = err_len_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          wr_s      = 1'b1;
          wr_idx_s  = {IDX_W{1'b0}};
          idx_nxt_s = IDX_W'(1);
          err_nxt_s = 1'b0;
          if (coef_in.s_last) begin
            if (TAPS == 1) begin
              state_nxt_s = ST_ARMED;
            end else begin
              err_nxt_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          wr_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            if (coef_in.s_last) begin
              state_nxt_s = ST_ARMED;
            end else begin
              err_nxt_s   = 1'b1;
              state_nxt_s = ST_DRAIN;
            end
          end else if (coef_in.s_last) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (xfer_s && coef_in.s_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_ARMED: begin
        if (commit) begin
          state_nxt_s = ST_PENDING;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_PENDING: begin
        if (sample_tick) begin
          swap_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      s_ready_r   <= 1'b0;
      armed_r     <= 1'b0;
      bank_sel_r  <= 1'b0;
      swap_done_r <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      s_ready_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD) ||
                     (state_nxt_s == ST_DRAIN);
      armed_r     <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_PENDING);
      bank_sel_r  <= bank_sel_r ^ swap_s;
      swap_done_r <= swap_s;
      err_len_r   <= err_nxt_s;
    end
  end

  // Bank storage: the active bank drives the FIR directly, so a swap exchanges contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        active_r[k] <= {COEF_W{1'b0}};
        shadow_r[k] <= {COEF_W{1'b0}};
      end
    end else if (swap_s) begin
      for (int k = 0; k < TAPS; k++) begin
        active_r[k] <= shadow_r[k];
        shadow_r[k] <= active_r[k];
      end
    end else if (wr_s) begin
      shadow_r[wr_idx_s] <= coef_in.s_data;
    end else begin
      shadow_r[wr_idx_s] <= shadow_r[wr_idx_s];
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_flat
    assign coef_flat[k*COEF_W +: COEF_W] = active_r[k];
  end

  assign coef_in.s_ready = s_ready_r;
  assign bank_sel        = bank_sel_r;
  assign armed           = armed_r;
  assign swap_done       = swap_done_r;
  assign err_len         = err_len_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised bench for fir_coeff_loader against a frame-level reference model.
module tb_fir_coeff_loader;
  localparam int TAPS   = 63;
  localparam int COEF_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic commit = 1'b0;
  logic sample_tick = 1'b0;
  logic [TAPS*COEF_W-1:0] coef_flat;
  logic bank_sel, armed, swap_done, err_len;

  fir_coeff_loader_if #(.COEF_W(COEF_W)) bus ();

  fir_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .coef_in(bus), .commit(commit),
    .sample_tick(sample_tick), .coef_flat(coef_flat), .bank_sel(bank_sel),
    .armed(armed), .swap_done(swap_done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: frame collection queue plus loaded/committed flags.
  logic [31:0] m_frame[$];
  logic [31:0] m_shadow[TAPS];
  logic [31:0] m_active[TAPS];
  bit m_wait, m_pend, m_drop, m_ready, m_err, m_swap, m_bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    for (int k = 0; k < TAPS; k++) begin
      m_shadow[k] = 32'd0;
      m_active[k] = 32'd0;
    end
    m_wait = 0; m_pend = 0; m_drop = 0; m_ready = 0;
    m_err = 0; m_swap = 0; m_bank = 0;
  endtask

  task automatic model_edge();
    bit sw;
    sw = 0;
    if (bus.s_valid && m_ready) begin
      if (m_drop) begin
        if (bus.s_last) m_drop = 0;
      end else begin
        if (m_frame.size() == 0) m_err = 0;
        m_frame.push_back(bus.s_data);
        if (m_frame.size() == TAPS) begin
          if (bus.s_last) begin
            for (int k = 0; k < TAPS; k++) m_shadow[k] = m_frame[k];
            m_wait = 1;
          end else begin
            m_err = 1;
            m_drop = 1;
          end
          m_frame.delete();
        end else if (bus.s_last) begin
          m_err = 1;
          m_frame.delete();
        end
      end
    end else if (m_wait && !m_pend) begin
      if (commit) m_pend = 1;
    end else if (m_pend && sample_tick) begin
      m_active = m_shadow;
      m_bank ^= 1'b1;
      sw = 1;
      m_wait = 0;
      m_pend = 0;
    end
    m_swap = sw;
    m_ready = !m_wait;
  endtask

  task automatic check_outputs();
    chk("s_ready", 32'(bus.s_ready), 32'(m_ready));
    chk("armed", 32'(armed), 32'(m_wait));
    chk("swap_done", 32'(swap_done), 32'(m_swap));
    chk("err_len", 32'(err_len), 32'(m_err));
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
    for (int k = 0; k < TAPS; k++)
      chk($sformatf("h%0d", k), coef_flat[k*COEF_W +: COEF_W], m_active[k]);
  endtask

  // One clock: model steps on the edge, DUT is sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic rand_ctrl();
    commit = ($urandom_range(0, 9) == 0);
    sample_tick = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_frame(input int n, input bit seq, input bit with_last);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        rand_ctrl();
        cycle();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = seq ? 32'(i + 1) : 32'($urandom);
      bus.s_last  = with_last && (i == n - 1);
      t = 0;
      do begin
        acc = m_ready;
        rand_ctrl();
        cycle();
        t++;
      end while (!acc && t < 50);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    commit = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic commit_then_tick(input int delay);
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    repeat (delay) cycle();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    commit = 1'b0;
    sample_tick = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 32'd0;
    bus.s_last  = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    cycle();

    // Nominal ramp frame, commit, tick three cycles later.
    send_frame(TAPS, 1'b1, 1'b1);
    repeat (2) cycle();
    commit_then_tick(3);

    // Commit and tick together while armed: only the later tick swaps.
    send_frame(TAPS, 1'b0, 1'b1);
    sample_tick = 1'b1;
    cycle();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    sample_tick = 1'b0;
    repeat (3) cycle();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    repeat (2) cycle();

    // Short frame, then a good frame.
    send_frame(10, 1'b0, 1'b1);
    repeat (2) cycle();
    send_frame(TAPS, 1'b0, 1'b1);
    commit_then_tick(1);

    // Long frame, followed by an ignored commit.
    send_frame(70, 1'b0, 1'b1);
    commit_then_tick(2);

    // Reset partway through a second frame.
    send_frame(TAPS, 1'b0, 1'b1);
    commit_then_tick(0);
    send_frame(30, 1'b0, 1'b0);
    do_reset();
    send_frame(TAPS, 1'b1, 1'b1);
    commit_then_tick(4);

    // Random mix of frame lengths and control timing.
    for (int r = 0; r < 24; r++) begin
      int len;
      case ($urandom_range(0, 5))
        0: len = 1;
        1: len = 10;
        2: len = 70;
        3: len = 62;
        default: len = TAPS;
      endcase
      send_frame(len, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        rand_ctrl();
        cycle();
      end
      commit = 1'b0;
      sample_tick = 1'b0;
      if (m_wait) commit_then_tick($urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
